// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state encodings (CLEAR sweep, READY service)
//   - MMIO word offsets inside the peripheral window (addr[3:2])
//   - STATUS register bit positions
//   - default base address of the peripheral window
package data_mem_responder_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [1:0] OFF_GPIO   = 2'd0;
    localparam logic [1:0] OFF_CYCLE  = 2'd1;
    localparam logic [1:0] OFF_TOHOST = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int STATUS_MISALIGN_BIT  = 0;
    localparam int STATUS_INIT_BUSY_BIT = 1;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'h8000;

endpackage

// File: rtl/data_mem_ram_array.sv
// Single-port word RAM: asynchronous read, synchronous write.
// Ports:
//   clk   in   clock
//   we    in   write enable (commits on posedge clk)
//   addr  in   word address, shared by read and write
//   wdata in   write data
//   rdata out  combinational read data of mem[addr]
// Preload hook: the storage array is named `mem`, so a simulation wrapper
// can fill it hierarchically through <inst>.mem before releasing reset.
module data_mem_ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory bus: word RAM plus a small MMIO
// window (GPIO, cycle counter, tohost exit register, status).
// Optional feature macro: DMEM_INIT_CLEAR_EN -- when defined, a clear sweep
// writes CLEAR_VALUE to every RAM word after reset (init_busy high); when
// undefined the responder comes out of reset ready and init_busy is 0.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   halt          pipeline halt: blocks writes and counter advance
//   mem_read_wrn  1 = read/idle, 0 = write
//   mem_address   byte address; bit 15 selects the MMIO window
//   mem_wdata     store data (whole word)
//   mem_rdata     combinational load data (0 during writes and sweep)
//   gpio_out      GPIO output register
//   test_done     one-cycle pulse after a tohost write
//   exit_code     last value written to tohost
//   init_busy     high while the clear sweep runs
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        mem_read_wrn,
    input  logic [15:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_out,
    output logic        test_done,
    output logic [31:0] exit_code,
    output logic        init_busy
);

    logic              clearing;
    logic [ADDR_W-1:0] clear_idx;

`ifdef DMEM_INIT_CLEAR_EN
    logic [0:0] state;

    // The sweep leaves CLEAR on the same edge that writes the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clear_idx <= clear_idx + 1'b1;
            if (clear_idx == '1) begin
                state <= ST_READY;
            end
        end
    end

    assign clearing = (state == ST_CLEAR);
`else
    assign clearing  = 1'b0;
    assign clear_idx = '0;
`endif

    logic              ready;
    logic              mmio_sel;
    logic [1:0]        mmio_off;
    logic [ADDR_W-1:0] word_idx;
    logic              wr_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       cycle_cnt;
    logic              misaligned;
    logic [31:0]       status;
    logic              unused_addr_bits;

    assign ready    = !clearing;
    assign mmio_sel = (mem_address[15] == MMIO_BASE[15]);
    assign mmio_off = mem_address[3:2];
    // Address bits above the RAM span alias onto the same words.
    assign word_idx = mem_address[ADDR_W+1:2];
    assign unused_addr_bits = ^mem_address[14:ADDR_W+2];

    assign wr_en = ready && !mem_read_wrn && !halt;

    // The sweep owns the single RAM port while it runs.
    assign ram_we    = clearing || (wr_en && !mmio_sel);
    assign ram_addr  = clearing ? clear_idx : word_idx;
    assign ram_wdata = clearing ? CLEAR_VALUE : mem_wdata;

    data_mem_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out   <= '0;
            exit_code  <= '0;
            test_done  <= 1'b0;
            cycle_cnt  <= '0;
            misaligned <= 1'b0;
        end else begin
            test_done <= wr_en && mmio_sel && (mmio_off == OFF_TOHOST);
            if (wr_en && mmio_sel && (mmio_off == OFF_GPIO)) begin
                gpio_out <= mem_wdata;
            end
            if (wr_en && mmio_sel && (mmio_off == OFF_TOHOST)) begin
                exit_code <= mem_wdata;
            end
            if (ready && !halt) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            // Idle cycles present address 0, so only real accesses trip this.
            if (ready && (mem_address[1:0] != 2'b00)) begin
                misaligned <= 1'b1;
            end
        end
    end

    always_comb begin
        status                       = '0;
        status[STATUS_MISALIGN_BIT]  = misaligned;
        status[STATUS_INIT_BUSY_BIT] = clearing;
    end

    always_comb begin
        mem_rdata = '0;
        if (ready && mem_read_wrn) begin
            if (mmio_sel) begin
                case (mmio_off)
                    OFF_GPIO:   mem_rdata = gpio_out;
                    OFF_CYCLE:  mem_rdata = cycle_cnt;
                    OFF_TOHOST: mem_rdata = exit_code;
                    default:    mem_rdata = status;
                endcase
            end else begin
                mem_rdata = ram_rdata;
            end
        end
    end

    assign init_busy = clearing;

endmodule
